// File: rtl/conv_stream_driver.sv
// Initiator for the streaming convolution engine: holds host-loaded x/f samples,
// streams them to the engine and captures the y results into a readable buffer.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | streaming x/f and collecting y
// DONE  | all beats exchanged, results valid, waiting for start
module conv_stream_driver #(
   parameter int X_LEN = 128,
   parameter int F_LEN = 32,
   parameter int DW    = 8,
   parameter int YW    = 21,
   localparam int AW   = $clog2(X_LEN)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          host_wr_en,
   input  logic          host_wr_sel,
   input  logic [AW-1:0] host_wr_addr,
   input  logic [DW-1:0] host_wr_data,
   input  logic          start,
   input  logic          stall_y,
   input  logic [AW-1:0] res_rd_addr,
   output logic [YW-1:0] res_rd_data,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] m_data_x,
   output logic          m_valid_x,
   input  logic          m_ready_x,
   output logic [DW-1:0] m_data_f,
   output logic          m_valid_f,
   input  logic          m_ready_f,
   input  logic [YW-1:0] s_data_y,
   input  logic          s_valid_y,
   output logic          s_ready_y
);

   localparam int NUM_Y = X_LEN - F_LEN + 1;
   localparam int FAW   = $clog2(F_LEN);
   localparam int CW    = AW + 1;
   localparam logic [CW-1:0] X_END = CW'(X_LEN);
   localparam logic [CW-1:0] F_END = CW'(F_LEN);
   localparam logic [CW-1:0] Y_END = CW'(NUM_Y);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   logic [CW-1:0] x_idx;
   logic [CW-1:0] f_idx;
   logic [CW-1:0] y_cnt;

   logic [DW-1:0] xbuf   [X_LEN];
   logic [DW-1:0] fbuf   [F_LEN];
   logic [YW-1:0] resbuf [NUM_Y];

   logic in_run;
   logic x_beat;
   logic f_beat;
   logic y_beat;

   // Counters run one past the last index so "finished" needs no extra flag.
   assign in_run    = (state == RUN);
   assign m_valid_x = in_run && (x_idx < X_END);
   assign m_valid_f = in_run && (f_idx < F_END);
   assign s_ready_y = in_run && !stall_y && (y_cnt < Y_END);
   assign m_data_x  = xbuf[x_idx[AW-1:0]];
   assign m_data_f  = fbuf[f_idx[FAW-1:0]];
   assign x_beat    = m_valid_x && m_ready_x;
   assign f_beat    = m_valid_f && m_ready_f;
   assign y_beat    = s_valid_y && s_ready_y;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         x_idx <= '0;
         f_idx <= '0;
         y_cnt <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state <= RUN;
                  busy  <= 1'b1;
                  done  <= 1'b0;
                  x_idx <= '0;
                  f_idx <= '0;
                  y_cnt <= '0;
               end
            end
            RUN: begin
               if (x_beat) x_idx <= x_idx + CW'(1);
               if (f_beat) f_idx <= f_idx + CW'(1);
               if (y_beat) y_cnt <= y_cnt + CW'(1);
               if (x_idx == X_END && f_idx == F_END && y_cnt == Y_END) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // Sample and result storage is deliberately left uninitialised by reset.
   always_ff @(posedge clk) begin
      if (host_wr_en && !busy) begin
         if (!host_wr_sel)
            xbuf[host_wr_addr] <= host_wr_data;
         else if ({1'b0, host_wr_addr} < F_END)
            fbuf[host_wr_addr[FAW-1:0]] <= host_wr_data;
      end
      if (y_beat)
         resbuf[y_cnt[AW-1:0]] <= s_data_y;
   end

   always_ff @(posedge clk) begin
      if (reset)
         res_rd_data <= '0;
      else if ({1'b0, res_rd_addr} < Y_END)
         res_rd_data <= resbuf[res_rd_addr];
      else
         res_rd_data <= '0;
   end

endmodule
